// File: rtl/mio_pkg.sv
// +----------------------------------------------------------------------+
// | mio_pkg : shared encodings and widths for the memory/IO responder    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mio_pkg;

  typedef enum logic [1:0] {
    MIO_IDLE = 2'd0,
    MIO_BUSY = 2'd1,
    MIO_DONE = 2'd2
  } mio_state_t;

  localparam logic [3:0] IO_BASE = 4'hF;
  localparam int         RAM_AW  = 10;
  localparam int         IO_AW   = 8;

endpackage

`default_nettype wire

// File: rtl/mio_wait_cnt.sv
// +----------------------------------------------------------------------+
// | mio_wait_cnt : 4-bit loadable down-counter for bus wait states       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mio_wait_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  // Load wins over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

`default_nettype wire

// File: rtl/mio_bus_resp.sv
// +----------------------------------------------------------------------+
// | mio_bus_resp : CPU memory/IO bus responder with per-region waits     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mio_bus_resp
  import mio_pkg::*;
#(
  parameter int unsigned RAM_WAIT = 2,
  parameter int unsigned IO_WAIT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       addr,
  input  logic [31:0]       Data_in,
  output logic [31:0]       Data_out,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  output logic [IO_AW-1:0]  io_addr,
  output logic [31:0]       io_din,
  output logic              io_we,
  output logic              io_rd,
  input  logic [31:0]       io_dout,
  output logic [1:0]        mio_state
);

  mio_state_t        state;
  mio_state_t        state_nxt;
  logic              is_wr;
  logic              is_io;
  logic [RAM_AW-1:0] addr_q;
  logic [31:0]       data_q;

  logic              req;
  logic              req_io;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;
  logic [3:0]        cnt_val;
  logic              access;

  // Byte-lane and upper RAM address bits are don't-care in this map.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr[27:RAM_AW+2], addr[1:0]};

  assign req     = CPU_MIO && (MemRead || MemWrite);
  assign req_io  = (addr[31:28] == IO_BASE);
  assign cnt_val = req_io ? 4'(IO_WAIT) : 4'(RAM_WAIT);
  assign access  = (state == MIO_BUSY) && cnt_zero;

  mio_wait_cnt u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .val   (cnt_val),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      MIO_IDLE: begin
        if (req) begin
          cnt_load  = 1'b1;
          state_nxt = MIO_BUSY;
        end
      end
      MIO_BUSY: begin
        if (cnt_zero) begin
          state_nxt = MIO_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      MIO_DONE: state_nxt = MIO_IDLE;
      default:  state_nxt = MIO_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= MIO_IDLE;
      is_wr    <= 1'b0;
      is_io    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      Data_out <= '0;
    end else begin
      state <= state_nxt;
      if ((state == MIO_IDLE) && req) begin
        is_wr  <= MemWrite;
        is_io  <= req_io;
        addr_q <= addr[RAM_AW+1:2];
        data_q <= Data_in;
      end
      if (access && !is_wr) begin
        Data_out <= is_io ? io_dout : ram_dout;
      end
    end
  end

  // Strobes depend on registered state only, never on live CPU inputs.
  assign ram_we    = access && is_wr && !is_io;
  assign io_we     = access && is_wr && is_io;
  assign io_rd     = access && !is_wr && is_io;
  assign MIO_ready = (state == MIO_DONE);

  assign ram_addr  = addr_q;
  assign io_addr   = addr_q[IO_AW-1:0];
  assign ram_din   = data_q;
  assign io_din    = data_q;
  assign mio_state = state;

endmodule

`default_nettype wire
